// File: rtl/uart_pkg.sv
// Shared UART definitions: the FSM state encoding, frame constants and the parity helper.
// The receive side imports this same package.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK,
    BRK_GUARD
  } uart_state_t;

  // Odd parity: data plus the returned bit always holds an odd number of ones.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO. The pointers carry one extra wrap bit so that full and
// empty can be told apart. Read data is taken directly from the array, so a pop
// sees the head entry in the same cycle.
module uart_tx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // A write into a full FIFO or a read from an empty one is ignored.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage array: no reset, contents are only meaningful between the pointers.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; reset discards everything queued.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_odd.sv
// UART transmitter, 8 data bits LSB first, odd parity, one stop bit.
// A FIFO absorbs bursts from the producer; queued frames go out back-to-back.
// TX is registered from the current state, so it trails the FSM by one cycle.
module uart_tx_odd
  import uart_pkg::*;
#(
  parameter int BaudRate  = 4,
  parameter int FifoDepth = 4
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic [DATA_BITS-1:0]       tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic                       break_req,
  output logic                       TX,
  output logic                       busy,
  output logic [$clog2(FifoDepth):0] fifo_count
);

  localparam int          BitIdxW  = $clog2(DATA_BITS);
  localparam logic [15:0] BaudLast = 16'(2 * BaudRate - 1);
  localparam logic [BitIdxW-1:0] LastBit = BitIdxW'(DATA_BITS - 1);

  uart_state_t            state_reg,    state_next;
  logic [15:0]            baud_cnt_reg, baud_cnt_next;
  logic [BitIdxW-1:0]     bit_idx_reg,  bit_idx_next;
  logic [DATA_BITS-1:0]   shreg_reg,    shreg_next;
  logic                   parity_reg,   parity_next;
  logic                   tx_next;
  logic                   baud_wrap;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rd_data;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign busy      = (state_reg != IDLE) || !fifo_empty;
  assign baud_wrap = (baud_cnt_reg == BaudLast);

  uart_tx_fifo #(
    .Width (DATA_BITS),
    .Depth (FifoDepth)
  ) u_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (fifo_push),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state logic: frame sequencing, FIFO pops and shift-register loading.
  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    shreg_next   = shreg_reg;
    parity_next  = parity_reg;
    fifo_pop     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (break_req) begin
          state_next = BREAK;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          shreg_next = {1'b0, shreg_reg[DATA_BITS-1:1]};
          if (bit_idx_reg == LastBit) begin
            state_next = PARITY;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_wrap) begin
          state_next = STOP;
        end
      end
      STOP: begin
        // Chaining straight into the next START keeps queued frames gap-free;
        // a pending break lets the current frame finish and then takes over via IDLE.
        if (baud_wrap) begin
          if (!fifo_empty && !break_req) begin
            fifo_pop   = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      BREAK: begin
        if (!break_req) begin
          state_next = BRK_GUARD;
        end
      end
      BRK_GUARD: begin
        if (baud_wrap) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (fifo_pop) begin
      shreg_next  = fifo_rd_data;
      parity_next = odd_parity(fifo_rd_data);
    end
  end

  // Bit-period timer: restarts on every state change so each state gets a full period.
  always_comb begin
    baud_cnt_next = baud_cnt_reg + 16'd1;
    if (state_reg == IDLE || state_next != state_reg || baud_wrap) begin
      baud_cnt_next = '0;
    end
  end

  // Line level for the current state.
  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      IDLE:      tx_next = 1'b1;
      START:     tx_next = 1'b0;
      DATA:      tx_next = shreg_reg[0];
      PARITY:    tx_next = parity_reg;
      STOP:      tx_next = 1'b1;
      BREAK:     tx_next = 1'b0;
      BRK_GUARD: tx_next = 1'b1;
      default:   tx_next = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight at once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shreg_reg    <= '0;
      parity_reg   <= 1'b0;
      TX           <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shreg_reg    <= shreg_next;
      parity_reg   <= parity_next;
      TX           <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_odd.sv
// Self-checking bench for uart_tx_odd: a scoreboard queue of accepted bytes is
// matched against frames decoded from the TX line.
module tb_uart_tx_odd;

  localparam int BAUD    = 4;
  localparam int DEPTH   = 4;
  localparam int BIT_CYC = 2 * BAUD;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       break_req = 1'b0;
  logic       tx_ready;
  logic       TX;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_count;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         frames_done = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         rst_seen = 1'b0;
  bit         chk_ready_en = 1'b0;
  bit         stalled = 1'b0;

  uart_tx_odd #(
    .BaudRate  (BAUD),
    .FifoDepth (DEPTH)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .break_req  (break_req),
    .TX         (TX),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Rst_n) rst_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; holds tx_valid until the byte is taken, returns at the next negedge.
  task automatic send(input logic [7:0] b);
    int g;
    g = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && g < 2000) begin
      stalled = 1'b1;
      @(negedge Clk);
      g++;
    end
    chk("push_accepted", 32'(g < 2000), 32'd1);
    exp_q.push_back(b);
    $display("[TB] push 0x%02h at cycle %0d", b, cyc);
    @(negedge Clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    chk(tag, 32'(n < 5000), 32'd1);
    repeat (4) @(negedge Clk);
  endtask

  // Line monitor: decode each frame at mid-bit and compare with the scoreboard head.
  initial begin : monitor
    logic       prev;
    logic       st;
    logic       par;
    logic       stp;
    logic [7:0] d;
    logic [7:0] e;
    int         t0;
    prev = 1'b1;
    d = 8'h00;
    forever begin
      @(negedge Clk);
      if (Rst_n && prev && !TX && !break_req) begin
        rst_seen = 1'b0;
        t0 = cyc;
        repeat (BAUD) @(negedge Clk);
        st = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(negedge Clk);
          d[i] = TX;
        end
        repeat (BIT_CYC) @(negedge Clk);
        par = TX;
        repeat (BIT_CYC) @(negedge Clk);
        stp = TX;
        repeat (BIT_CYC - BAUD - 1) @(negedge Clk);
        if (!rst_seen) begin
          start_q.push_back(t0);
          chk("start_bit", 32'(st), 32'd0);
          chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data_byte", 32'(d), 32'(e));
            chk("parity_bit", 32'(par), 32'(($countones(e) % 2) == 0));
            chk("stop_bit", 32'(stp), 32'd1);
            $display("[TB] frame 0x%02h par %0d stop %0d expected 0x%02h at cycle %0d",
                     d, par, stp, e, t0);
          end
          frames_done++;
        end
      end
      prev = TX;
    end
  end

  // While streaming, tx_ready must mirror the occupancy and never exceed the depth.
  always @(negedge Clk) begin
    if (chk_ready_en && Rst_n) begin
      chk("ready_vs_full", 32'(tx_ready), 32'(fifo_count != DEPTH));
      chk("count_le_depth", 32'(fifo_count <= DEPTH), 32'd1);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int fd0;
    int lows;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Single byte 0x55: latency and busy duration
    send(8'h55);
    chk("lat_edge_n", 32'(TX), 32'd1);
    @(negedge Clk);
    chk("lat_edge_n1", 32'(TX), 32'd1);
    @(negedge Clk);
    chk("lat_edge_n2", 32'(TX), 32'd0);
    n = 2;
    while (busy && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("busy_drop_window", 32'(n >= 88 && n <= 90), 32'd1);
    wait_idle("t_single_done");

    // Parity corners
    send(8'h00);
    send(8'h01);
    send(8'hFF);
    wait_idle("t_parity_done");

    // Back-to-back stream with back-pressure
    start_q.delete();
    chk_ready_en = 1'b1;
    stalled = 1'b0;
    for (int b = 8'h10; b <= 8'h15; b++) begin
      send(8'(b));
    end
    wait_idle("t_stream_done");
    chk_ready_en = 1'b0;
    chk("stream_backpressure", 32'(stalled), 32'd1);
    chk("stream_frames", 32'(start_q.size()), 32'd6);
    for (int i = 1; i < start_q.size(); i++) begin
      chk("stream_gap", 32'(start_q[i] - start_q[i-1]), 32'd88);
    end

    // Break requested mid-frame
    send(8'hA5);
    send(8'h3C);
    repeat (30) @(negedge Clk);
    fd0 = frames_done;
    break_req = 1'b1;
    n = 0;
    while (frames_done == fd0 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("break_frame1_done", 32'(n < 300), 32'd1);
    repeat (3) @(negedge Clk);
    chk("break_low_a", 32'(TX), 32'd0);
    chk("break_holds_queue", 32'(fifo_count), 32'd1);
    send(8'h81);
    chk("break_push_accepted", 32'(fifo_count), 32'd2);
    repeat (20) @(negedge Clk);
    chk("break_low_b", 32'(TX), 32'd0);
    break_req = 1'b0;
    n = 0;
    while (!TX && n < 50) begin
      @(negedge Clk);
      n++;
    end
    n = 0;
    while (TX && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("guard_high_len", 32'(n >= 8 && n <= 10), 32'd1);
    wait_idle("t_break_done");

    // Asynchronous reset during PARITY with two bytes queued
    send(8'h01);
    send(8'h22);
    send(8'h44);
    chk("pre_reset_count", 32'(fifo_count), 32'd2);
    repeat (75) @(negedge Clk);
    chk("pre_reset_parity_tx", 32'(TX), 32'd0);
    Rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(TX), 32'd1);
    chk("async_rst_count", 32'(fifo_count), 32'd0);
    chk("async_rst_ready", 32'(tx_ready), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge Clk);
      if (!TX) lows++;
    end
    chk("no_frame_after_reset", 32'(lows), 32'd0);
    send(8'h5A);
    wait_idle("t_reset_done");

    // Push and pop in the same cycle at count 2
    send(8'h61);
    send(8'h62);
    send(8'h63);
    repeat (86) @(negedge Clk);
    chk("pp_count_before", 32'(fifo_count), 32'd2);
    send(8'h64);
    chk("pp_count_after", 32'(fifo_count), 32'd2);
    wait_idle("t_pushpop_done");

    // Push attempt while full, with a pop in the same cycle
    send(8'h71);
    send(8'h72);
    send(8'h73);
    send(8'h74);
    send(8'h75);
    chk("full_count", 32'(fifo_count), 32'd4);
    repeat (84) @(negedge Clk);
    chk("full_ready_low_at_pop", 32'(tx_ready), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    @(negedge Clk);
    tx_valid = 1'b0;
    chk("full_pop_count", 32'(fifo_count), 32'd3);
    wait_idle("t_full_done");

    repeat (20) @(negedge Clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
